// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit restoring divider for DIV/DIVU.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   start      in   1  request a division (sampled only in idle)
//   annul      in   1  abort any in-flight division; wins over start
//   signed_div in   1  1 = DIV (two's complement), 0 = DIVU
//   a          in  32  dividend
//   b          in  32  divisor
//   result     out 64  {remainder, quotient}; registered
//   ready      out  1  one-cycle pulse, result valid
//   busy       out  1  division in progress (stall request)
//
// Build option: define DIV_ZERO_FAST_EN to finish a divide-by-zero in two
// cycles with a zero result. Left undefined, b == 0 runs all 32 steps.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic        signed_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StZero, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  // Partial remainder stays below 2^32 (below the divisor, or the dividend's
  // upper bits for a zero divisor), so its 33rd bit is only needed transiently
  // in the shifted value below.
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] result_q, result_d;

  logic [31:0] a_abs, b_abs;
  logic [32:0] shifted;
  logic        step_ok;
  logic [31:0] step_rem, step_quo;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    a_abs = (signed_div && a[31]) ? 32'd0 - a : a;
    b_abs = (signed_div && b[31]) ? 32'd0 - b : b;

    // One restoring step: shift in the next dividend bit, trial-subtract.
    shifted  = {rem_q, quo_q[31]};
    step_ok  = shifted >= {1'b0, dvs_q};
    // When the subtract succeeds the true difference fits in 32 bits.
    step_rem = step_ok ? shifted[31:0] - dvs_q : shifted[31:0];
    step_quo = {quo_q[30:0], step_ok};

    quo_fix  = qneg_q ? 32'd0 - step_quo : step_quo;
    rem_fix  = rneg_q ? 32'd0 - step_rem : step_rem;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          dvs_d   = b_abs;
          quo_d   = a_abs;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          qneg_d  = signed_div & (a[31] ^ b[31]);
          rneg_d  = signed_div & a[31];
          state_d = StRun;
`ifdef DIV_ZERO_FAST_EN
          if (b == 32'd0) state_d = StZero;
`endif
        end
      end
      StZero: begin
        result_d = 64'd0;
        state_d  = StDone;
      end
      StRun: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          result_d = {rem_fix, quo_fix};
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything except reset; result must not move.
    if (annul) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      dvs_q    <= 32'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == StDone);
  assign busy   = (state_q == StRun) || (state_q == StZero);

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed vectors, expected {rem, quo} and the cycle
// of ready are queued at issue time and checked by an independent monitor.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .annul      (annul),
    .signed_div (signed_div),
    .a          (a),
    .b          (b),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [63:0] last_res = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ready: got result %h want no ready (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result", result, e.res);
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
        last_res = e.res;
      end
    end
  end

  // Called at posedge+1; leaves start low at the next posedge+1.
  task automatic issue(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                       input logic [63:0] exp_res, input int lat, input logic push);
    exp_t e;
    start      = 1'b1;
    signed_div = sd;
    a          = av;
    b          = bv;
    e.res      = exp_res;
    e.cyc      = cyc + lat;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready want %0d pending", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", 64'(ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);

    // DIVU 100/7 with busy window check.
    issue(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 1'b1);
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      chk("busy_window", 64'(busy), (k <= 32) ? 64'd1 : 64'd0);
    end
    wait_done();

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b1);
    wait_done();
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33, 1'b1);
    wait_done();
    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 33, 1'b1);
    wait_done();

`ifdef DIV_ZERO_FAST_EN
    issue(1'b0, 32'd5, 32'd0, 64'd0, 2, 1'b1);
`else
    issue(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 33, 1'b1);
`endif
    wait_done();

    // Annul at t+10: no ready, result held, fresh start at t+11.
    issue(1'b0, 32'd9999, 32'd4, 64'd0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    chk("annul_busy", 64'(busy), 64'd0);
    chk("annul_ready", 64'(ready), 64'd0);
    chk("annul_result", result, last_res);
    issue(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33, 1'b1);
    wait_done();

    // Reset at t+20 with start held; start at t+21 begins a new division.
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd12345;
    b          = 32'd10;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_result", result, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    begin
      exp_t e;
      e.res = {32'd5, 32'd1234};
      e.cyc = cyc + 33;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("rst_restart_busy", 64'(busy), 64'd1);
    wait_done();

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
